// File: rtl/lap_memory.sv
// Stopwatch lap memory: captures up to DEPTH lap times on button presses and
// replays them oldest-first in a recall (VIEW) mode.
module lap_memory #(
    parameter int DIGITS = 6,
    parameter int DEPTH  = 8,
    parameter int WRAP   = 1,
    localparam int W     = 4 * DIGITS,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  time_in,
    input  logic          lap_btn,
    input  logic          view_btn,
    input  logic          clr_btn,
    output logic [W-1:0]  disp_out,
    output logic          viewing,
    output logic [CW-1:0] lap_count,
    output logic [CW-1:0] view_idx,
    output logic          full,
    output logic          ovf
);

    typedef enum logic {
        RECORD = 1'b0,
        VIEW   = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] wr_ptr, wr_ptr_n;
    logic [PW-1:0] rd_ptr, rd_ptr_n;
    logic [CW-1:0] cnt_n, idx_n;
    logic          ovf_n;
    logic          we;

    logic          lap_q, view_q, clr_q;
    logic          armed;
    logic          lap_p, view_p, clr_p;

    logic [W-1:0]  mem [DEPTH];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // armed stays low for the first edge after reset so a button already held
    // through reset only loads its history register instead of counting.
    assign lap_p  = armed & lap_btn  & ~lap_q;
    assign view_p = armed & view_btn & ~view_q;
    assign clr_p  = armed & clr_btn  & ~clr_q;

    assign full     = (lap_count == CW'(DEPTH));
    assign viewing  = (state == VIEW);
    assign disp_out = (state == VIEW) ? mem[rd_ptr] : time_in;

    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        cnt_n    = lap_count;
        idx_n    = view_idx;
        ovf_n    = 1'b0;
        we       = 1'b0;
        if (clr_p) begin
            state_n  = RECORD;
            wr_ptr_n = '0;
            cnt_n    = '0;
            idx_n    = '0;
        end else if (lap_p) begin
            if (state == RECORD) begin
                if (!full) begin
                    we       = 1'b1;
                    wr_ptr_n = next_ptr(wr_ptr);
                    cnt_n    = lap_count + CW'(1);
                end else if (WRAP != 0) begin
                    // Full ring: wr_ptr already points at the oldest entry.
                    we       = 1'b1;
                    wr_ptr_n = next_ptr(wr_ptr);
                    ovf_n    = 1'b1;
                end else begin
                    ovf_n    = 1'b1;
                end
            end
        end else if (view_p) begin
            if (state == RECORD) begin
                if (lap_count != '0) begin
                    state_n  = VIEW;
                    rd_ptr_n = full ? wr_ptr : '0;
                    idx_n    = CW'(1);
                end
            end else if (view_idx < lap_count) begin
                rd_ptr_n = next_ptr(rd_ptr);
                idx_n    = view_idx + CW'(1);
            end else begin
                state_n = RECORD;
                idx_n   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RECORD;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lap_count <= '0;
            view_idx  <= '0;
            ovf       <= 1'b0;
            lap_q     <= 1'b0;
            view_q    <= 1'b0;
            clr_q     <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= state_n;
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            lap_count <= cnt_n;
            view_idx  <= idx_n;
            ovf       <= ovf_n;
            lap_q     <= lap_btn;
            view_q    <= view_btn;
            clr_q     <= clr_btn;
            armed     <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr] <= time_in;
        end
    end

endmodule

// File: tb/tb_lap_memory.sv
// Directed bench for lap_memory (DIGITS=6, DEPTH=4): one overwriting and one
// dropping instance, checked by a cycle-stamped expected queue.
module tb_lap_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] time_in = 24'h123456;
    logic        lap_w = 1'b0, view_w = 1'b0, clr_w = 1'b0;
    logic        lap_d = 1'b0, view_d = 1'b0, clr_d = 1'b0;

    logic [23:0] disp_w, disp_d;
    logic        viewing_w, viewing_d, full_w, full_d, ovf_w, ovf_d;
    logic [2:0]  cnt_w, cnt_d, idx_w, idx_d;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        bit          sel;
        string       name;
        logic [23:0] disp;
        logic        viewing;
        logic [2:0]  cnt;
        logic [2:0]  idx;
        logic        full;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    lap_memory #(.DIGITS(6), .DEPTH(4), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .time_in(time_in),
        .lap_btn(lap_w), .view_btn(view_w), .clr_btn(clr_w),
        .disp_out(disp_w), .viewing(viewing_w), .lap_count(cnt_w),
        .view_idx(idx_w), .full(full_w), .ovf(ovf_w)
    );

    lap_memory #(.DIGITS(6), .DEPTH(4), .WRAP(0)) u_drop (
        .clk(clk), .rst(rst), .time_in(time_in),
        .lap_btn(lap_d), .view_btn(view_d), .clr_btn(clr_d),
        .disp_out(disp_d), .viewing(viewing_d), .lap_count(cnt_d),
        .view_idx(idx_d), .full(full_d), .ovf(ovf_d)
    );

    // clock / cycle stamp
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // monitor: compares every entry whose cycle stamp has come due
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            logic [23:0] a_disp;
            logic        a_v, a_f, a_o;
            logic [2:0]  a_c, a_i;
            e = exp_q.pop_front();
            checks++;
            a_disp = e.sel ? disp_d    : disp_w;
            a_v    = e.sel ? viewing_d : viewing_w;
            a_c    = e.sel ? cnt_d     : cnt_w;
            a_i    = e.sel ? idx_d     : idx_w;
            a_f    = e.sel ? full_d    : full_w;
            a_o    = e.sel ? ovf_d     : ovf_w;
            if (e.due < cyc) begin
                errors++;
                $display("FAIL %s: check stamped cycle %0d not sampled (now %0d)", e.name, e.due, cyc);
            end else if (a_disp !== e.disp || a_v !== e.viewing || a_c !== e.cnt ||
                         a_i !== e.idx || a_f !== e.full || a_o !== e.ovf) begin
                errors++;
                $display("FAIL %s (cyc %0d): got disp=%h viewing=%b cnt=%0d idx=%0d full=%b ovf=%b, want disp=%h viewing=%b cnt=%0d idx=%0d full=%b ovf=%b",
                         e.name, cyc, a_disp, a_v, a_c, a_i, a_f, a_o,
                         e.disp, e.viewing, e.cnt, e.idx, e.full, e.ovf);
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input bit sel, input string name, input int lat,
                       input logic [23:0] d, input logic v, input logic [2:0] c,
                       input logic [2:0] i, input logic f, input logic o);
        exp_t x;
        x.due = cyc + lat; x.sel = sel; x.name = name;
        x.disp = d; x.viewing = v; x.cnt = c; x.idx = i; x.full = f; x.ovf = o;
        exp_q.push_back(x);
    endtask

    task automatic set_btn(input bit sel, input logic l, input logic v, input logic c);
        if (sel) begin
            lap_d = l; view_d = v; clr_d = c;
        end else begin
            lap_w = l; view_w = v; clr_w = c;
        end
    endtask

    // One-cycle press, checked right after the acting edge, then an idle cycle.
    task automatic press(input bit sel, input logic l, input logic v, input logic c,
                         input string name, input logic [23:0] d, input logic vw,
                         input logic [2:0] cn, input logic [2:0] ix,
                         input logic f, input logic o);
        set_btn(sel, l, v, c);
        chk(sel, name, 1, d, vw, cn, ix, f, o);
        tick();
        set_btn(sel, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        // reset held low
        tick(); tick();
        chk(0, "reset_wrap", 1, 24'h123456, 0, 0, 0, 0, 0);
        chk(1, "reset_drop", 1, 24'h123456, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        tick();

        // three laps then full recall cycle
        time_in = 24'h000105; press(0, 1, 0, 0, "lap1", 24'h000105, 0, 1, 0, 0, 0);
        time_in = 24'h000210; press(0, 1, 0, 0, "lap2", 24'h000210, 0, 2, 0, 0, 0);
        time_in = 24'h000315; press(0, 1, 0, 0, "lap3", 24'h000315, 0, 3, 0, 0, 0);
        time_in = 24'h999999;
        press(0, 0, 1, 0, "view1", 24'h000105, 1, 3, 1, 0, 0);
        press(0, 0, 1, 0, "view2", 24'h000210, 1, 3, 2, 0, 0);
        press(0, 0, 1, 0, "view3", 24'h000315, 1, 3, 3, 0, 0);
        press(0, 0, 1, 0, "view_exit", 24'h999999, 0, 3, 0, 0, 0);

        // empty recall ignored; lap ignored in VIEW
        press(0, 0, 0, 1, "clr", 24'h999999, 0, 0, 0, 0, 0);
        press(0, 0, 1, 0, "view_empty", 24'h999999, 0, 0, 0, 0, 0);
        time_in = 24'h000777;
        press(0, 1, 0, 0, "lap_single", 24'h000777, 0, 1, 0, 0, 0);
        time_in = 24'h000888;
        press(0, 0, 1, 0, "view_single", 24'h000777, 1, 1, 1, 0, 0);
        press(0, 1, 0, 0, "lap_in_view", 24'h000777, 1, 1, 1, 0, 0);
        press(0, 0, 1, 0, "view_single_exit", 24'h000888, 0, 1, 0, 0, 0);
        press(0, 0, 0, 1, "clr2", 24'h000888, 0, 0, 0, 0, 0);

        // overwrite mode: six laps into four slots
        for (int k = 1; k <= 6; k++) begin
            time_in = 24'(k);
            press(0, 1, 0, 0, "wrap_lap", 24'(k), 0, 3'((k > 4) ? 4 : k), 0, k >= 4, k > 4);
        end
        time_in = 24'h999999;
        chk(0, "wrap_ovf_clear", 1, 24'h999999, 0, 4, 0, 1, 0);
        tick();
        for (int k = 0; k < 4; k++)
            press(0, 0, 1, 0, "wrap_recall", 24'(k + 3), 1, 4, 3'(k + 1), 1, 0);
        press(0, 0, 1, 0, "wrap_exit", 24'h999999, 0, 4, 0, 1, 0);

        // drop mode: six laps into four slots
        for (int k = 1; k <= 6; k++) begin
            time_in = 24'(k);
            press(1, 1, 0, 0, "drop_lap", 24'(k), 0, 3'((k > 4) ? 4 : k), 0, k >= 4, k > 4);
        end
        time_in = 24'h999999;
        for (int k = 0; k < 4; k++)
            press(1, 0, 1, 0, "drop_recall", 24'(k + 1), 1, 4, 3'(k + 1), 1, 0);
        press(1, 0, 1, 0, "drop_exit", 24'h999999, 0, 4, 0, 1, 0);

        // simultaneous lap/view/clr with two laps stored
        press(0, 0, 0, 1, "clr3", 24'h999999, 0, 0, 0, 0, 0);
        time_in = 24'h000011; press(0, 1, 0, 0, "pri_lap1", 24'h000011, 0, 1, 0, 0, 0);
        time_in = 24'h000022; press(0, 1, 0, 0, "pri_lap2", 24'h000022, 0, 2, 0, 0, 0);
        press(0, 1, 1, 1, "pri_all", 24'h000022, 0, 0, 0, 0, 0);

        // reset mid-VIEW with lap held through release
        time_in = 24'h000033; press(0, 1, 0, 0, "rst_lap", 24'h000033, 0, 1, 0, 0, 0);
        time_in = 24'h555555; press(0, 0, 1, 0, "rst_view", 24'h000033, 1, 1, 1, 0, 0);
        rst = 1'b0;
        lap_w = 1'b1;
        chk(0, "rst_async", 0, 24'h555555, 0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b1;
        chk(0, "rst_release_held", 1, 24'h555555, 0, 0, 0, 0, 0);
        tick(); tick();
        chk(0, "rst_still_held", 1, 24'h555555, 0, 0, 0, 0, 0);
        tick();
        lap_w = 1'b0;
        tick();
        press(0, 1, 0, 0, "rst_new_lap", 24'h555555, 0, 1, 0, 0, 0);
        press(0, 0, 1, 0, "rst_new_view", 24'h555555, 1, 1, 1, 0, 0);

        // report
        tick(); tick();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: %0d expected entries never compared, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lap_memory.md
LAP_MEMORY -- requirements
Module: lap_memory

Interface
REQ-001 SHALL have parameter DIGITS, default 6, number of 4-bit BCD digits per stored time.
REQ-002 SHALL have parameter DEPTH, default 8, number of lap slots; legal range 2..64.
REQ-003 SHALL have parameter WRAP, default 1; 1 = overwrite oldest lap when full, 0 = drop new laps when full.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port time_in, input, 4*DIGITS, live stopwatch time; most significant digit in the top nibble.
REQ-007 SHALL have port lap_btn, input, 1, debounced, clk-synchronous level; a press stores a lap.
REQ-008 SHALL have port view_btn, input, 1, debounced, clk-synchronous level; a press enters or steps recall.
REQ-009 SHALL have port clr_btn, input, 1, debounced, clk-synchronous level; a press erases all laps.
REQ-010 SHALL have port disp_out, output, 4*DIGITS, time to display.
REQ-011 SHALL have port viewing, output, 1, high in VIEW state.
REQ-012 SHALL have port lap_count, output, CW = clog2(DEPTH+1), number of valid laps.
REQ-013 SHALL have port view_idx, output, CW, 1-based chronological index of the displayed lap; 0 in RECORD.
REQ-014 SHALL have port full, output, 1, high when lap_count == DEPTH.
REQ-015 SHALL have port ovf, output, 1, one-cycle pulse on a lap press that overwrote (WRAP=1) or was dropped (WRAP=0).

Function
REQ-016 SHALL detect a press as btn sampled high at a clk edge and low at the previous edge (one register per button); a held level SHALL count as one press.
REQ-017 SHALL act on a press at the same clk edge that detects it; registered outputs reflect the action immediately after that edge.
REQ-018 SHALL implement states RECORD and VIEW; disp_out SHALL equal time_in combinationally in RECORD and the selected stored lap in VIEW.
REQ-019 SHALL, on a lap press in RECORD, store time_in into slot wr_ptr, advance wr_ptr modulo DEPTH, and increment lap_count saturating at DEPTH.
REQ-020 SHALL, on a lap press in RECORD when full and WRAP=1, overwrite the oldest lap, keep lap_count = DEPTH, and pulse ovf.
REQ-021 SHALL, on a lap press in RECORD when full and WRAP=0, leave memory and pointers unchanged and pulse ovf.
REQ-022 SHALL ignore lap presses in VIEW (no store, no ovf).
REQ-023 SHALL, on a view press in RECORD with lap_count > 0, enter VIEW selecting the oldest lap (slot 0 if not wrapped, else slot wr_ptr) with view_idx = 1.
REQ-024 SHALL ignore a view press in RECORD when lap_count == 0.
REQ-025 SHALL, on a view press in VIEW with view_idx < lap_count, select the next slot modulo DEPTH and increment view_idx.
REQ-026 SHALL, on a view press in VIEW with view_idx == lap_count, return to RECORD with view_idx = 0.
REQ-027 SHALL, on a clr press in either state, set lap_count, wr_ptr and view_idx to 0 and enter RECORD; memory contents need not be cleared.
REQ-028 SHALL resolve same-cycle presses with priority clr > lap > view; lower-priority presses in that cycle are discarded.
REQ-029 SHALL store time_in bit-exact; no BCD validation or arithmetic.

Reset
REQ-030 SHALL, while rst is low, hold state RECORD, lap_count = 0, wr_ptr = 0, view_idx = 0, viewing = 0, full = 0, ovf = 0, button history registers = 0.
REQ-031 SHALL, on reset asserted mid-VIEW, abandon recall immediately and show time_in on disp_out.
REQ-032 SHALL NOT register a press on the first edge after reset release if the button was already held during reset.

Verification (DIGITS=6, DEPTH=4)
REQ-033 SHALL verify: laps at time_in 0x000105, 0x000210, 0x000315 then three view presses -> disp_out 0x000105, 0x000210, 0x000315 with view_idx 1, 2, 3; fourth press -> viewing=0, disp_out = time_in.
REQ-034 SHALL verify (WRAP=1): six laps with values 1..6 -> lap_count 4, full 1, ovf pulsed on laps 5 and 6; recall order 3, 4, 5, 6.
REQ-035 SHALL verify (WRAP=0): six laps with values 1..6 -> lap_count 4, recall order 1, 2, 3, 4, ovf pulsed twice.
REQ-036 SHALL verify: view press with zero laps -> viewing stays 0; lap press in VIEW -> lap_count unchanged.
REQ-037 SHALL verify: lap, view and clr pressed in the same cycle with 2 laps stored -> lap_count 0, viewing 0, ovf 0.
REQ-038 SHALL verify: rst low during VIEW with lap_btn held across release -> RECORD, lap_count 0, no lap stored until lap_btn falls and rises again.
